// File: rtl/project2_pio_pkg.sv
// rtl/project2_pio_pkg.sv - shared constants and types for the LED output PIO
package project2_pio_pkg;

  localparam int DIV_W_DEFAULT = 24;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
  localparam logic [2:0] ADDR_BLINK_DIV  = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

  typedef enum logic {
    PHASE0 = 1'b0,
    PHASE1 = 1'b1
  } phase_e;

endpackage

// File: rtl/project2_leds_out_if.sv
// rtl/project2_leds_out_if.sv - Avalon-MM slave bus bundle for the LED output PIO
interface project2_leds_out_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/project2_blink_timer.sv
// rtl/project2_blink_timer.sv - prescaler that toggles the blink phase every div cycles
module project2_blink_timer
  import project2_pio_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output phase_e           phase,
  output phase_e           phase_next
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;

  // Counter and phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= PHASE0;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

  // Next state: a divider write or a zero divider parks the engine in PHASE0;
  // otherwise wrap the counter and flip the phase at the end of each half-period.
  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (restart || (div == '0)) begin
      cnt_next   = '0;
      phase_next = PHASE0;
    end else if (cnt == (div - DIV_W'(1))) begin
      cnt_next   = '0;
      phase_next = (phase == PHASE0) ? PHASE1 : PHASE0;
    end else begin
      cnt_next = cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/project2_leds_out.sv
// rtl/project2_leds_out.sv - LED output PIO with set/clear aliases and per-bit blink
module project2_leds_out
  import project2_pio_pkg::*;
#(
  parameter int               WIDTH       = 12,
  parameter int               DIV_W       = DIV_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  project2_leds_out_if.slave  bus,
  output logic [WIDTH-1:0]    out_port
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [DIV_W-1:0] div_q;

  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] mask_next;
  logic [DIV_W-1:0] div_next;
  logic             div_wr;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux;
  phase_e           phase;
  phase_e           phase_next;

  // Bits of writedata above the register widths are deliberately dropped.
  logic unused_writedata;
  assign unused_writedata = ^bus.writedata;

  assign wr_en = bus.chipselect && !bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  project2_blink_timer #(
    .DIV_W (DIV_W)
  ) u_blink_timer (
    .clk        (clk),
    .reset      (reset),
    .div        (div_q),
    .restart    (div_wr),
    .phase      (phase),
    .phase_next (phase_next)
  );

  // Register write decode, including the atomic set/clear aliases of DATA.
  always_comb begin
    data_next = data_q;
    mask_next = mask_q;
    div_next  = div_q;
    div_wr    = 1'b0;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:       data_next = wdata;
        ADDR_BLINK_MASK: mask_next = wdata;
        ADDR_BLINK_DIV: begin
          div_next = bus.writedata[DIV_W-1:0];
          div_wr   = 1'b1;
        end
        ADDR_OUTSET:     data_next = data_q | wdata;
        ADDR_OUTCLEAR:   data_next = data_q & ~wdata;
        default:         ;
      endcase
    end
  end

  // Read mux; write-only and reserved addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:       rd_mux = 32'(data_q);
      ADDR_BLINK_MASK: rd_mux = 32'(mask_q);
      ADDR_BLINK_DIV:  rd_mux = 32'(div_q);
      ADDR_STATUS:     rd_mux = {31'd0, phase == PHASE1};
      default:         rd_mux = '0;
    endcase
  end

  // Register file, registered read data and LED drive built from next-state
  // values so a write shows on the pins right after its edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= RESET_VALUE;
      mask_q       <= '0;
      div_q        <= '0;
      bus.readdata <= '0;
      out_port     <= RESET_VALUE;
    end else begin
      data_q       <= data_next;
      mask_q       <= mask_next;
      div_q        <= div_next;
      bus.readdata <= rd_mux;
      out_port     <= data_next ^ (mask_next & {WIDTH{phase_next == PHASE1}});
    end
  end

endmodule

// File: tb/tb_project2_leds_out.sv
// tb/tb_project2_leds_out.sv - directed self-checking bench for project2_leds_out
module tb_project2_leds_out;

  logic        clk;
  logic        reset;
  logic [11:0] out_port;
  int          checks;
  int          errors;

  project2_leds_out_if bus ();

  project2_leds_out #(
    .WIDTH       (12),
    .DIV_W       (24),
    .RESET_VALUE (12'h0A5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_out_port", 32'(out_port), 32'h0A5);
    chk("reset_readdata", bus.readdata, 32'h0);
    bus.address = 3'd3;
    tick();
    chk("reset_status", bus.readdata, 32'h0);

    // Reset wins over a simultaneous DATA write.
    bus.address    = 3'd0;
    bus.writedata  = 32'h123;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    reset          = 1'b1;
    tick();
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    tick();
    chk("reset_vs_write_data", bus.readdata, 32'h0A5);
    chk("reset_vs_write_out", 32'(out_port), 32'h0A5);

    // DATA, OUTCLEAR, OUTSET.
    wr(3'd0, 32'hFFF);
    chk("data_fff", 32'(out_port), 32'hFFF);
    wr(3'd5, 32'h00F);
    chk("outclear_00f", 32'(out_port), 32'hFF0);
    wr(3'd4, 32'h100);
    chk("outset_100", 32'(out_port), 32'hFF0);
    bus.address = 3'd0;
    tick();
    chk("read_data_ff0", bus.readdata, 32'h0000_0FF0);
    wr(3'd0, 32'h00F);
    chk("read_old_after_write", bus.readdata, 32'h0FF0);
    tick();
    chk("read_new_next_cycle", bus.readdata, 32'h000F);

    // Blink with divider 4.
    wr(3'd1, 32'h003);
    wr(3'd0, 32'h000);
    wr(3'd2, 32'd4);
    chk("blink_e0", 32'(out_port), 32'h000);
    bus.address = 3'd3;
    tick(); tick(); tick();
    chk("blink_e3", 32'(out_port), 32'h000);
    tick();
    chk("blink_e4", 32'(out_port), 32'h003);
    tick();
    chk("blink_e5_status", bus.readdata, 32'h1);
    chk("blink_e5", 32'(out_port), 32'h003);
    tick(); tick();
    chk("blink_e7", 32'(out_port), 32'h003);
    tick();
    chk("blink_e8", 32'(out_port), 32'h000);
    tick();
    chk("blink_e9_status", bus.readdata, 32'h0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("blink_e15", 32'(out_port), 32'h003);

    // Shrink divider mid-period: phase forced to 0, next toggle 2 cycles later.
    wr(3'd2, 32'd2);
    chk("div2_restart", 32'(out_port), 32'h000);
    tick();
    chk("div2_e17", 32'(out_port), 32'h000);
    tick();
    chk("div2_e18", 32'(out_port), 32'h003);

    // Divider 1 toggles every cycle; DATA write coincides with a toggle.
    wr(3'd2, 32'd1);
    chk("div1_f0", 32'(out_port), 32'h000);
    tick();
    chk("div1_f1", 32'(out_port), 32'h003);
    tick();
    chk("div1_f2", 32'(out_port), 32'h000);
    tick();
    chk("div1_f3", 32'(out_port), 32'h003);
    wr(3'd0, 32'h010);
    chk("div1_data_and_toggle", 32'(out_port), 32'h010);
    tick();
    chk("div1_f5", 32'(out_port), 32'h013);

    // Divider 0 parks the blink.
    wr(3'd2, 32'd0);
    chk("div0_settle", 32'(out_port), 32'h010);
    tick(); tick(); tick();
    chk("div0_hold", 32'(out_port), 32'h010);
    chk("div0_readback", bus.readdata, 32'h0);
    bus.address = 3'd3;
    tick();
    chk("div0_status", bus.readdata, 32'h0);

    // Ignored writes and reserved/write-only reads.
    bus.address    = 3'd0;
    bus.writedata  = 32'hABC;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b0;
    tick();
    bus.write_n    = 1'b1;
    chk("cs0_out", 32'(out_port), 32'h010);
    chk("cs0_read", bus.readdata, 32'h010);
    wr(3'd6, 32'hFFF);
    wr(3'd7, 32'hFFF);
    chk("reserved_wr_out", 32'(out_port), 32'h010);
    for (int a = 4; a < 8; a++) begin
      bus.address = 3'(a);
      tick();
      chk($sformatf("read_zero_addr%0d", a), bus.readdata, 32'h0);
    end
    bus.address = 3'd1;
    tick();
    chk("mask_readback", bus.readdata, 32'h003);
    bus.address = 3'd0;
    tick();
    chk("data_after_reserved", bus.readdata, 32'h010);
    wr(3'd0, 32'hFFFF_F123);
    chk("upper_bits_out", 32'(out_port), 32'h123);
    tick();
    chk("upper_bits_read", bus.readdata, 32'h0000_0123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/project2_leds_out.md
# project2_leds_out

Avalon-MM memory-mapped output port driving the board LEDs; the write-direction counterpart of the input PIO that samples the push-buttons. It holds a data register with atomic bit-set and bit-clear aliases, and a per-bit blink engine: a programmable prescaler toggles a phase bit that inverts masked output bits. It sits on the Nios II data bus alongside the button PIO and drives pins directly.

## Interface
- WIDTH, 12, number of output bits.
- DIV_W, 24, width of blink half-period divider.
- RESET_VALUE, 0, value of DATA and `out_port` after reset.

- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register being accessed.
- chipselect  in  1  slave select; writes are ignored when low.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  registered read data, zero-extended.
- out_port  out  WIDTH  registered LED drive.

## Operation
- Register map (word addresses):
  - 0 DATA, R/W, WIDTH bits.
  - 1 BLINK_MASK, R/W, WIDTH bits.
  - 2 BLINK_DIV, R/W, DIV_W bits; half-period in clk cycles; 0 disables blinking.
  - 3 STATUS, RO; bit0 = phase.
  - 4 OUTSET, WO: DATA |= writedata[WIDTH-1:0].
  - 5 OUTCLEAR, WO: DATA &= ~writedata[WIDTH-1:0].
  - 6-7: reserved; writes ignored, reads 0.
- Write accepted on any edge with chipselect=1 and write_n=0. One access per cycle; no wait states.
- Read path: no read strobe. Every cycle, readdata <= zero-extended register selected by address. Addresses 4-7 read 0.
- Blink engine (two states, PHASE0/PHASE1, held in `phase`), counter `cnt` of width DIV_W:
  - BLINK_DIV=0: cnt held at 0, phase held at 0.
  - Otherwise cnt increments each cycle. When cnt == BLINK_DIV-1: cnt <= 0 and phase toggles.
  - Any write to BLINK_DIV forces cnt <= 0 and phase <= 0 on the same edge. This avoids an overrun when a smaller divider is written.
- out_port <= DATA_next ^ (BLINK_MASK_next & {WIDTH{phase_next}}), registered.
- Reset values:
  - DATA = RESET_VALUE; BLINK_MASK = 0; BLINK_DIV = 0; cnt = 0; phase = 0.
  - readdata = 0; out_port = RESET_VALUE.
- Reset has priority over any write in the same cycle. Mid-blink reset returns to PHASE0 with the counter at 0.

## Timing
- Write at edge N: the register and out_port both reflect the new value after edge N. out_port is computed from next-state values, so there is no extra cycle.
- Read latency 1: address presented before edge N gives readdata valid after edge N.
- Read of a register written on edge N, with address held: readdata shows the old value after N and the new value after N+1.
- With BLINK_DIV=D≠0 and no intervening writes, phase toggles every D cycles. Period is 2·D cycles. D=1 toggles every cycle.
- Simultaneous events:
  - A phase toggle and a DATA/OUTSET/OUTCLEAR/BLINK_MASK write on the same edge both take effect; out_port reflects both.
  - A mask bit cleared while phase=1 returns that pin to its DATA value on the same edge.

## Structure
- Shared package `project2_pio_pkg`:
  - address constants ADDR_DATA..ADDR_OUTCLEAR;
  - DIV_W default;
  - a typedef for the blink phase enum (PHASE0/PHASE1).
- One sub-module, `project2_blink_timer`:
  - inputs: div, restart, clk, reset;
  - outputs: phase;
  - contains cnt and the toggle logic.
- The top level holds the register file, read mux and output logic.

## Test plan
- Reset with RESET_VALUE=0x0A5: out_port=0x0A5, readdata=0, STATUS=0. Assert reset during a write to DATA: write is lost, DATA=0x0A5.
- Write DATA=0xFFF, then OUTCLEAR 0x00F, then OUTSET 0x100. Expected: out_port 0xFFF → 0xFF0 → 0xFF0. Reading addr 0 returns 0x00000FF0 one cycle after address.
- BLINK_MASK=0x003, DATA=0x000, BLINK_DIV=4. Expected: out_port alternates 0x000/0x003 every 4 cycles from the DIV write; STATUS bit0 tracks phase.
- Same setup, rewrite BLINK_DIV=2 at cnt=3, phase=1. Expected: phase forced 0 that edge, next toggle 2 cycles later.
- BLINK_DIV=1: out_port toggles masked bits every cycle. BLINK_DIV=0 afterwards: masked bits settle to DATA and stay there.
- Write with chipselect=0, and writes to addresses 6/7: no register changes. Reads of addresses 4-7 return 0. Writedata bits 31:12 are ignored for WIDTH=12.
